// File: rtl/risc_pkg.sv
// rtl/risc_pkg.sv - shared RISC pipeline register-file constants and decode encodings
package risc_pkg;

  localparam int REG_SEL_W = 3;
  localparam int NUM_REGS  = 8;

  typedef enum logic [1:0] {
    WB_NONE = 2'b00,
    WB_LOW  = 2'b01,
    WB_HIGH = 2'b10,
    WB_FULL = 2'b11
  } wb_enable_e;

  typedef enum logic [1:0] {
    INSTR_NOP   = 2'b00,
    INSTR_ARITH = 2'b01,
    INSTR_MEM   = 2'b10,
    INSTR_AUDIO = 2'b11
  } instr_type_e;

  // A latency must be at least one cycle and representable in a busy counter.
  function automatic bit latency_fits(int lat, int cnt_w);
    return (lat >= 1) && (lat <= (1 << cnt_w) - 1);
  endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// rtl/hazard_scoreboard_if.sv - IF/ID fields seen by the scoreboard and the stall/issue it returns
interface hazard_scoreboard_if;
  import risc_pkg::*;

  logic                 id_valid;
  logic                 id_is_memory;
  logic [REG_SEL_W-1:0] id_src1;
  logic [REG_SEL_W-1:0] id_src2;
  logic                 id_src1_used;
  logic                 id_src2_used;
  logic [REG_SEL_W-1:0] id_dest;
  logic [1:0]           id_wb_enable;
  logic                 flush;
  logic                 stall;
  logic                 issue;

  modport master (
    output id_valid, id_is_memory, id_src1, id_src2, id_src1_used, id_src2_used,
    output id_dest, id_wb_enable, flush,
    input  stall, issue
  );

  modport slave (
    input  id_valid, id_is_memory, id_src1, id_src2, id_src1_used, id_src2_used,
    input  id_dest, id_wb_enable, flush,
    output stall, issue
  );

endinterface

// File: rtl/reg_busy_counter.sv
// rtl/reg_busy_counter.sv - per-register saturating down-counter with load priority
module reg_busy_counter #(
  parameter int CNT_W = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_value,
  output logic [CNT_W-1:0] count,
  output logic             busy
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // A new writeback wins over the decrement; otherwise count down and rest at zero.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_value;
    end else if (count_q != '0) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  // Counter register, cleared by the asynchronous active-low reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign busy  = (count_q != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - register-hazard interlock; HAZARD_STALL_COUNT_EN adds the stall_cycles counter
module hazard_scoreboard #(
  parameter int NUM_REGS    = 8,
  parameter int CNT_W       = 3,
  parameter int ALU_LATENCY = 3,
  parameter int MEM_LATENCY = 5
) (
  input  logic                clock,
  input  logic                reset,
  hazard_scoreboard_if.slave  sb,
  output logic [NUM_REGS-1:0] busy_mask
`ifdef HAZARD_STALL_COUNT_EN
  ,
  output logic [31:0]         stall_cycles
`endif
);
  import risc_pkg::*;

  if (!latency_fits(ALU_LATENCY, CNT_W) || !latency_fits(MEM_LATENCY, CNT_W)) begin : g_bad_latency
    $error("hazard_scoreboard: ALU_LATENCY/MEM_LATENCY must be in 1..2**CNT_W-1");
  end
  if (NUM_REGS != (1 << REG_SEL_W)) begin : g_bad_regs
    $error("hazard_scoreboard: NUM_REGS must match the register select width");
  end

  // Counters hold the cycles still to wait before decode may read the register.
  // The issue cycle is the first latency cycle, so a writeback loads lat-1 and the
  // register reads back current exactly lat cycles after issue.
  localparam logic [CNT_W-1:0] ALU_LAT  = CNT_W'(ALU_LATENCY);
  localparam logic [CNT_W-1:0] MEM_LAT  = CNT_W'(MEM_LATENCY);
  localparam logic [CNT_W-1:0] ALU_LOAD = CNT_W'(ALU_LATENCY - 1);
  localparam logic [CNT_W-1:0] MEM_LOAD = CNT_W'(MEM_LATENCY - 1);

  logic [CNT_W-1:0]    cnt [NUM_REGS];
  logic [NUM_REGS-1:0] busy;
  logic [NUM_REGS-1:0] load;
  logic [CNT_W-1:0]    lat;
  logic [CNT_W-1:0]    load_value;
  logic                raw;
  logic                waw;
  logic                stall_int;
  logic                issue_int;

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    reg_busy_counter #(.CNT_W(CNT_W)) u_cnt (
      .clock      (clock),
      .reset      (reset),
      .load       (load[i]),
      .load_value (load_value),
      .count      (cnt[i]),
      .busy       (busy[i])
    );
  end

  // Hazard detection against pre-issue counters, then issue and destination reload.
  always_comb begin
    lat        = sb.id_is_memory ? MEM_LAT : ALU_LAT;
    load_value = sb.id_is_memory ? MEM_LOAD : ALU_LOAD;
    raw        = (sb.id_src1_used && busy[sb.id_src1]) ||
                 (sb.id_src2_used && busy[sb.id_src2]);
    waw        = (sb.id_wb_enable != WB_NONE) && (cnt[sb.id_dest] > lat);
    stall_int  = sb.id_valid && !sb.flush && (raw || waw);
    issue_int  = sb.id_valid && !sb.flush && !stall_int;
    load       = '0;
    if (issue_int && (sb.id_wb_enable != WB_NONE)) begin
      load[sb.id_dest] = 1'b1;
    end
  end

  assign sb.stall  = stall_int;
  assign sb.issue  = issue_int;
  assign busy_mask = busy;

`ifdef HAZARD_STALL_COUNT_EN
  logic [31:0] stall_cycles_q;
  logic [31:0] stall_cycles_d;

  // Count every stalled cycle; the adder wraps at 2^32.
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (stall_int) begin
      stall_cycles_d = stall_cycles_q + 32'd1;
    end
  end

  // Stall counter register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stall_cycles_q <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
`else
  // No stall counter in this build.
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - self-checking bench for hazard_scoreboard
module tb_hazard_scoreboard;

  localparam int ALU_LAT = 3;
  localparam int MEM_LAT = 5;
  localparam int NTBL    = 25;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] busy_mask;
`ifdef HAZARD_STALL_COUNT_EN
  logic [31:0] stall_cycles;
`endif

  hazard_scoreboard_if hif();

  hazard_scoreboard #(
    .NUM_REGS    (8),
    .CNT_W       (3),
    .ALU_LATENCY (ALU_LAT),
    .MEM_LATENCY (MEM_LAT)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .sb        (hif),
    .busy_mask (busy_mask)
`ifdef HAZARD_STALL_COUNT_EN
    ,
    .stall_cycles (stall_cycles)
`endif
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic       valid;
    logic       mem;
    logic [2:0] src1;
    logic       s1u;
    logic [2:0] src2;
    logic       s2u;
    logic [2:0] dest;
    logic [1:0] wb;
    logic       flush;
    logic       exp_stall;
    logic       exp_issue;
    logic [7:0] exp_busy;
  } vec_t;

  vec_t tbl [NTBL];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model: cycle at which each register becomes readable.
  int ready [8];
  int now;
  int exp_stall_cnt;

  function automatic vec_t mk(logic valid, logic mem, logic [2:0] src1, logic s1u,
                              logic [2:0] src2, logic s2u, logic [2:0] dest,
                              logic [1:0] wb, logic flush, logic es, logic ei,
                              logic [7:0] eb);
    vec_t v;
    v.valid = valid; v.mem = mem; v.src1 = src1; v.s1u = s1u;
    v.src2 = src2; v.s2u = s2u; v.dest = dest; v.wb = wb; v.flush = flush;
    v.exp_stall = es; v.exp_issue = ei; v.exp_busy = eb;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) ready[i] = 0;
    now = 0;
    exp_stall_cnt = 0;
  endtask

  function automatic logic [7:0] m_busy();
    logic [7:0] b;
    for (int i = 0; i < 8; i++) b[i] = (ready[i] > now);
    return b;
  endfunction

  task automatic m_eval(input vec_t v, output logic st, output logic is);
    int   lat;
    logic raw;
    logic waw;
    lat = v.mem ? MEM_LAT : ALU_LAT;
    raw = (v.s1u && ready[v.src1] > now) || (v.s2u && ready[v.src2] > now);
    waw = (v.wb != 2'b00) && ((ready[v.dest] - now) > lat);
    st  = v.valid && !v.flush && (raw || waw);
    is  = v.valid && !v.flush && !st;
  endtask

  task automatic commit(input vec_t v);
    logic st;
    logic is;
    m_eval(v, st, is);
    if (st) exp_stall_cnt++;
    if (is && v.wb != 2'b00) ready[v.dest] = now + (v.mem ? MEM_LAT : ALU_LAT);
    now++;
  endtask

  task automatic apply(input vec_t v);
    @(negedge clock);
    hif.id_valid     = v.valid;
    hif.id_is_memory = v.mem;
    hif.id_src1      = v.src1;
    hif.id_src1_used = v.s1u;
    hif.id_src2      = v.src2;
    hif.id_src2_used = v.s2u;
    hif.id_dest      = v.dest;
    hif.id_wb_enable = v.wb;
    hif.flush        = v.flush;
    #1;
  endtask

  initial begin
    vec_t v;
    logic es;
    logic ei;
    int   tbl_stalls;

    // Hand-computed sequence from reset; each row is one cycle.
    tbl[0]  = mk(1,0,3'd2,1,3'd0,0,3'd0,2'b00,0, 0,1,8'h00);
    tbl[1]  = mk(1,0,3'd0,0,3'd0,0,3'd3,2'b11,0, 0,1,8'h00);
    tbl[2]  = mk(1,0,3'd3,1,3'd0,0,3'd1,2'b00,0, 1,0,8'h08);
    tbl[3]  = mk(1,0,3'd3,1,3'd0,0,3'd1,2'b00,0, 1,0,8'h08);
    tbl[4]  = mk(1,0,3'd3,1,3'd0,0,3'd1,2'b00,0, 0,1,8'h00);
    tbl[5]  = mk(1,1,3'd0,0,3'd0,0,3'd5,2'b01,0, 0,1,8'h00);
    tbl[6]  = mk(1,0,3'd0,0,3'd0,0,3'd5,2'b11,0, 1,0,8'h20);
    tbl[7]  = mk(1,0,3'd0,0,3'd0,0,3'd5,2'b11,0, 0,1,8'h20);
    tbl[8]  = mk(0,0,3'd0,0,3'd0,0,3'd0,2'b00,0, 0,0,8'h20);
    tbl[9]  = mk(0,0,3'd0,0,3'd0,0,3'd0,2'b00,0, 0,0,8'h20);
    tbl[10] = mk(0,0,3'd0,0,3'd0,0,3'd0,2'b00,0, 0,0,8'h00);
    tbl[11] = mk(1,0,3'd0,0,3'd0,0,3'd3,2'b11,0, 0,1,8'h00);
    tbl[12] = mk(1,0,3'd3,1,3'd0,0,3'd1,2'b00,1, 0,0,8'h08);
    tbl[13] = mk(1,0,3'd3,1,3'd0,0,3'd1,2'b00,1, 0,0,8'h08);
    tbl[14] = mk(1,0,3'd3,1,3'd0,0,3'd1,2'b00,0, 0,1,8'h00);
    tbl[15] = mk(1,0,3'd4,1,3'd0,0,3'd4,2'b11,0, 0,1,8'h00);
    tbl[16] = mk(1,0,3'd4,1,3'd0,0,3'd4,2'b11,0, 1,0,8'h10);
    tbl[17] = mk(1,0,3'd4,1,3'd0,0,3'd4,2'b11,0, 1,0,8'h10);
    tbl[18] = mk(1,0,3'd4,1,3'd0,0,3'd4,2'b11,0, 0,1,8'h00);
    tbl[19] = mk(1,0,3'd0,0,3'd4,1,3'd0,2'b00,0, 1,0,8'h10);
    tbl[20] = mk(1,0,3'd0,0,3'd4,1,3'd0,2'b00,0, 1,0,8'h10);
    tbl[21] = mk(1,0,3'd0,0,3'd4,1,3'd0,2'b00,0, 0,1,8'h00);
    tbl[22] = mk(1,1,3'd0,0,3'd0,0,3'd6,2'b10,0, 0,1,8'h00);
    tbl[23] = mk(1,0,3'd6,0,3'd6,0,3'd6,2'b00,0, 0,1,8'h40);
    tbl[24] = mk(1,1,3'd0,0,3'd0,0,3'd6,2'b11,0, 0,1,8'h40);

    // Reset state.
    reset = 1'b0;
    v = mk(0,0,3'd0,0,3'd0,0,3'd0,2'b00,0, 0,0,8'h00);
    apply(v);
    apply(v);
    check("reset_busy", 32'(busy_mask), 32'h0);
    check("reset_stall_idle", 32'(hif.stall), 32'h0);
    check("reset_issue_idle", 32'(hif.issue), 32'h0);
    v = mk(1,0,3'd2,1,3'd0,0,3'd0,2'b00,0, 0,0,8'h00);
    apply(v);
    check("reset_issue_valid", 32'(hif.issue), 32'h1);
    check("reset_stall_valid", 32'(hif.stall), 32'h0);
    @(negedge clock);
    reset = 1'b1;
    model_reset();

    // Table-driven directed vectors.
    tbl_stalls = 0;
    for (int i = 0; i < NTBL; i++) begin
      apply(tbl[i]);
      check($sformatf("vec%0d_stall", i), 32'(hif.stall), 32'(tbl[i].exp_stall));
      check($sformatf("vec%0d_issue", i), 32'(hif.issue), 32'(tbl[i].exp_issue));
      check($sformatf("vec%0d_busy", i), 32'(busy_mask), 32'(tbl[i].exp_busy));
      if (tbl[i].exp_stall) tbl_stalls++;
      commit(tbl[i]);
    end
    v = mk(0,0,3'd0,0,3'd0,0,3'd0,2'b00,0, 0,0,8'h00);
    apply(v);
`ifdef HAZARD_STALL_COUNT_EN
    check("tbl_stall_cycles", stall_cycles, 32'(tbl_stalls));
`endif
    commit(v);

    // Reset asserted during a stall on a pending load to r5.
    v = mk(1,1,3'd0,0,3'd0,0,3'd5,2'b11,0, 0,0,8'h00);
    apply(v);
    check("rst_seq_load_issue", 32'(hif.issue), 32'h1);
    commit(v);
    v = mk(1,0,3'd5,1,3'd0,0,3'd1,2'b00,0, 0,0,8'h00);
    apply(v);
    check("rst_seq_dep_stall", 32'(hif.stall), 32'h1);
    check("rst_seq_busy_pre", 32'(busy_mask), 32'(m_busy()));
    reset = 1'b0;
    #1;
    check("rst_seq_busy_async", 32'(busy_mask), 32'h0);
    check("rst_seq_stall_async", 32'(hif.stall), 32'h0);
    @(negedge clock);
    reset = 1'b1;
    model_reset();
    apply(v);
    check("rst_seq_dep_nostall", 32'(hif.stall), 32'h0);
    check("rst_seq_dep_issue", 32'(hif.issue), 32'h1);
`ifdef HAZARD_STALL_COUNT_EN
    check("rst_seq_stall_cycles", stall_cycles, 32'(exp_stall_cnt));
`endif
    commit(v);

    // Randomized stimulus against the reference model.
    for (int c = 0; c < 600; c++) begin
      v.valid = ($urandom_range(0, 9) < 8);
      v.mem   = ($urandom_range(0, 2) == 0);
      v.src1  = 3'($urandom_range(0, (c < 300) ? 3 : 7));
      v.s1u   = ($urandom_range(0, 1) == 1);
      v.src2  = 3'($urandom_range(0, (c < 300) ? 3 : 7));
      v.s2u   = ($urandom_range(0, 2) == 0);
      v.dest  = 3'($urandom_range(0, (c < 300) ? 3 : 7));
      v.wb    = 2'($urandom_range(0, 3));
      v.flush = ($urandom_range(0, 9) == 0);
      v.exp_stall = 1'b0;
      v.exp_issue = 1'b0;
      v.exp_busy  = 8'h00;
      apply(v);
      m_eval(v, es, ei);
      check($sformatf("rand%0d_stall", c), 32'(hif.stall), 32'(es));
      check($sformatf("rand%0d_issue", c), 32'(hif.issue), 32'(ei));
      check($sformatf("rand%0d_busy", c), 32'(busy_mask), 32'(m_busy()));
      commit(v);
    end

    v = mk(0,0,3'd0,0,3'd0,0,3'd0,2'b00,0, 0,0,8'h00);
    apply(v);
`ifdef HAZARD_STALL_COUNT_EN
    check("rand_stall_cycles", stall_cycles, 32'(exp_stall_cnt));
`endif
    commit(v);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
